// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 1/2-word instructions and steps
// the datapath through fetch, latch and execute phases.
module instr_sequencer #(
  parameter int          AW        = 16,
  parameter logic [7:0]  OP_LIMM32 = 8'hD0,
  parameter logic [7:0]  OP_LBSET  = 8'hD1,
  parameter logic [7:0]  OP_END    = 8'hFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_data,
  input  logic          exec_hold,
  output logic [31:0]   instr0,
  output logic [31:0]   instr1,
  output logic [3:0]    current_state,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic [31:0]   retired
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH0 = 4'd1,
    S_LATCH0 = 4'd2,
    S_FETCH1 = 4'd3,
    S_LATCH1 = 4'd4,
    S_EXEC   = 4'd5,
    S_HALT   = 4'd6
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   i0_q, i0_d;
  logic [31:0]   i1_q, i1_d;
  logic [31:0]   ret_q, ret_d;

  logic [7:0] rd_op;
  logic [7:0] cur_op;
  logic       rd_two;
  logic       cur_two;

  assign rd_op   = imem_data[31:24];
  assign cur_op  = i0_q[31:24];
  assign rd_two  = (rd_op == OP_LIMM32) || (rd_op == OP_LBSET);
  assign cur_two = (cur_op == OP_LIMM32) || (cur_op == OP_LBSET);

  // Next-state, PC, fetch address and instruction latch logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    i0_d    = i0_q;
    i1_d    = i1_q;
    ret_d   = ret_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = start_addr;
          ret_d   = '0;
          state_d = S_FETCH0;
        end
      end
      S_FETCH0: begin
        addr_d  = pc_q;
        state_d = S_LATCH0;
      end
      S_LATCH0: begin
        i0_d = imem_data;
        i1_d = '0;
        if (rd_op == OP_END) state_d = S_HALT;
        else if (rd_two)     state_d = S_FETCH1;
        else                 state_d = S_EXEC;
      end
      S_FETCH1: begin
        addr_d  = pc_q + AW'(1);
        state_d = S_LATCH1;
      end
      S_LATCH1: begin
        i1_d    = imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!exec_hold) begin
          ret_d   = ret_q + 32'd1;
          pc_d    = pc_q + (cur_two ? AW'(2) : AW'(1));
          state_d = S_FETCH0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      i0_q    <= '0;
      i1_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      i0_q    <= i0_d;
      i1_q    <= i1_d;
      ret_q   <= ret_d;
    end
  end

  // Address is live during fetch states so the memory returns data next cycle
  assign imem_addr     = addr_d;
  assign instr0        = i0_q;
  assign instr1        = i1_q;
  assign pc            = pc_q;
  assign retired       = ret_q;
  assign current_state = state_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted        = (state_q == S_HALT);

endmodule
